// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF and MEM requests onto the 8-bit RAM port.
// Optional MEMCTRL_IO_FULL_EN adds io_buffer_full back-pressure for stores to the IO range.
`ifndef AddrLen
`define AddrLen 32
`endif
`ifndef RegLen
`define RegLen 32
`endif

module mem_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 if_req,
    input  logic [`AddrLen-1:0]  if_addr,
    output logic [`RegLen-1:0]   if_data,
    output logic                 if_done,
    input  logic                 mem_load,
    input  logic                 mem_store,
    input  logic [`AddrLen-1:0]  mem_addr,
    input  logic [2:0]           mem_nbytes,
    input  logic [`RegLen-1:0]   mem_wdata,
    output logic [`RegLen-1:0]   mem_rdata,
    output logic                 mem_done,
    input  logic [7:0]           ram_din,
    output logic [7:0]           ram_dout,
    output logic [`AddrLen-1:0]  ram_a,
    output logic                 ram_wr
`ifdef MEMCTRL_IO_FULL_EN
    ,
    input  logic                 io_buffer_full
`endif
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, IOWAIT} state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic [2:0]          nbytes;
    logic                owner_mem;
    logic                wr_flag;
    logic [`RegLen-1:0]  data;
    logic [`RegLen-1:0]  data_next;
    logic [`RegLen-1:0]  wdata;
    logic [2:0]          req_n;
`ifdef MEMCTRL_IO_FULL_EN
    logic [`AddrLen-1:0] base;
    logic                io_store;
    logic                io_gap;
`endif

    assign ram_wr = wr_flag & rdy;

    always_comb begin
        case (mem_nbytes)
            3'd1:    req_n = 3'd1;
            3'd2:    req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    // cnt addresses have been issued, so the byte returning now belongs to index cnt-1
    always_comb begin
        data_next = data;
        case (cnt)
            3'd1:    data_next[7:0]   = ram_din;
            3'd2:    data_next[15:8]  = ram_din;
            3'd3:    data_next[23:16] = ram_din;
            3'd4:    data_next[31:24] = ram_din;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nbytes    <= '0;
            owner_mem <= 1'b0;
            wr_flag   <= 1'b0;
            data      <= '0;
            wdata     <= '0;
            ram_a     <= '0;
            ram_dout  <= '0;
            if_data   <= '0;
            if_done   <= 1'b0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
`ifdef MEMCTRL_IO_FULL_EN
            base      <= '0;
            io_store  <= 1'b0;
            io_gap    <= 1'b0;
`endif
        end else if (rdy) begin
            case (state)
                IDLE: begin
`ifdef MEMCTRL_IO_FULL_EN
                    if (io_gap) io_gap <= 1'b0;
                    else
`endif
                    if (mem_store) begin
                        owner_mem <= 1'b1;
                        nbytes    <= req_n;
                        cnt       <= '0;
`ifdef MEMCTRL_IO_FULL_EN
                        if (mem_addr[17:16] == 2'b11) begin
                            state    <= IOWAIT;
                            base     <= mem_addr;
                            wdata    <= mem_wdata;
                            io_store <= 1'b1;
                        end else
`endif
                        begin
                            state    <= WRITE;
                            ram_a    <= mem_addr;
                            ram_dout <= mem_wdata[7:0];
                            wdata    <= {8'h00, mem_wdata[31:8]};
                            wr_flag  <= 1'b1;
                        end
                    end else if (mem_load) begin
                        state     <= READ;
                        owner_mem <= 1'b1;
                        nbytes    <= req_n;
                        cnt       <= '0;
                        data      <= '0;
                        ram_a     <= mem_addr;
                    end else if (if_req) begin
                        state     <= READ;
                        owner_mem <= 1'b0;
                        nbytes    <= 3'd4;
                        cnt       <= '0;
                        data      <= '0;
                        ram_a     <= if_addr;
                    end
                end
`ifdef MEMCTRL_IO_FULL_EN
                IOWAIT: begin
                    if (!io_buffer_full) begin
                        state    <= WRITE;
                        ram_a    <= base;
                        ram_dout <= wdata[7:0];
                        wdata    <= {8'h00, wdata[31:8]};
                        wr_flag  <= 1'b1;
                    end
                end
`endif
                READ: begin
                    data <= data_next;
                    if (cnt == nbytes) begin
                        state <= DONE;
                        ram_a <= '0;
                        if (owner_mem) begin
                            mem_done  <= 1'b1;
                            mem_rdata <= data_next;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= data_next;
                        end
                    end else begin
                        cnt   <= cnt + 3'd1;
                        ram_a <= ram_a + 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt == nbytes - 3'd1) begin
                        state     <= DONE;
                        wr_flag   <= 1'b0;
                        ram_dout  <= '0;
                        ram_a     <= '0;
                        mem_done  <= 1'b1;
                        mem_rdata <= '0;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        ram_a    <= ram_a + 1'b1;
                        ram_dout <= wdata[7:0];
                        wdata    <= {8'h00, wdata[31:8]};
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    if_done   <= 1'b0;
                    mem_done  <= 1'b0;
                    if_data   <= '0;
                    mem_rdata <= '0;
`ifdef MEMCTRL_IO_FULL_EN
                    // an IO store leaves one dead cycle before the next accept
                    io_gap    <= io_store;
                    io_store  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
